// File: rtl/ioctl_ddram_loader_pkg.sv
// Shared types and DDRAM port widths for the ioctl-to-DDRAM download loader.
package ioctl_ddram_loader_pkg;

  localparam int DDR_AW = 29;
  localparam int DDR_DW = 64;
  localparam int DDR_BW = 8;
  localparam int FIFO_W = DDR_AW + DDR_DW + DDR_BW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [DDR_AW-1:0] addr;
    logic [DDR_DW-1:0] data;
    logic [DDR_BW-1:0] be;
  } ddr_word_t;

endpackage

// File: rtl/ioctl_ddram_loader_fifo.sv
// Small write FIFO between the word assembler and the DDRAM write port.
module loader_fifo
  import ioctl_ddram_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FIFO_W
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need one,
  // since an empty FIFO never exposes stale entries.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_ddram_loader.sv
// Collects 16-bit ioctl download writes into byte-masked 64-bit words and
// streams them to the DDRAM write port through a small FIFO.
module ioctl_ddram_loader
  import ioctl_ddram_loader_pkg::*;
#(
  parameter logic [7:0]        INDEX     = 8'd1,
  parameter logic [DDR_AW-1:0] BASE_ADDR = 29'h0600000,
  parameter int                DEPTH     = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [15:0]         ioctl_dout,
  output logic                ioctl_wait,
  input  logic                DDRAM_BUSY,
  input  logic                DDRAM_DOUT_READY,
  output logic [7:0]          DDRAM_BURSTCNT,
  output logic [DDR_AW-1:0]   DDRAM_ADDR,
  output logic [DDR_DW-1:0]   DDRAM_DIN,
  output logic [DDR_BW-1:0]   DDRAM_BE,
  output logic                DDRAM_WE,
  output logic                DDRAM_RD,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t      state;
  logic        active;
  logic        active_q;
  logic        dl_q;
  logic        wr_acc;
  logic [21:0] waddr;
  logic [1:0]  lane;

  logic        asm_valid, asm_valid_nxt;
  logic [21:0] asm_addr, asm_addr_nxt;
  logic [63:0] asm_data, asm_data_nxt;
  logic [7:0]  asm_mask, asm_mask_nxt;

  logic          push;
  ddr_word_t     push_w;
  logic [FIFO_W-1:0] head;
  ddr_word_t     head_w;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          unused;

  assign active = ioctl_download && (ioctl_index == INDEX);
  assign wr_acc = (state == ST_LOAD) && active && ioctl_wr;
  assign waddr  = ioctl_addr[24:3];
  assign lane   = ioctl_addr[2:1];
  assign unused = ^{DDRAM_DOUT_READY, ioctl_addr[0]};

  // Word assembler: merge lanes, push on full mask, word change or flush.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    push          = 1'b0;
    push_w        = '{addr: {7'b0, asm_addr}, data: asm_data, be: asm_mask};
    asm_valid_nxt = asm_valid;
    asm_addr_nxt  = asm_addr;
    asm_data_nxt  = asm_data;
    asm_mask_nxt  = asm_mask;
    if (wr_acc) begin
      if (asm_valid && (waddr != asm_addr)) begin
        push         = 1'b1;
        asm_data_nxt = '0;
        asm_mask_nxt = '0;
      end else if (!asm_valid) begin
        asm_data_nxt = '0;
        asm_mask_nxt = '0;
      end
      asm_addr_nxt                         = waddr;
      asm_data_nxt[{lane, 4'b0} +: 16]     = ioctl_dout;
      asm_mask_nxt[{lane, 1'b0} +: 2]      = 2'b11;
      asm_valid_nxt                        = 1'b1;
      if (!push && (asm_mask_nxt == 8'hFF)) begin
        push          = 1'b1;
        push_w        = '{addr: {7'b0, waddr}, data: asm_data_nxt, be: asm_mask_nxt};
        asm_valid_nxt = 1'b0;
      end
    end else if ((state == ST_FLUSH) && asm_valid) begin
      push          = 1'b1;
      asm_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      active_q  <= 1'b0;
      dl_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      asm_valid <= 1'b0;
      asm_addr  <= '0;
      asm_data  <= '0;
      asm_mask  <= '0;
    end else begin
      active_q  <= active;
      dl_q      <= ioctl_download;
      done      <= 1'b0;
      asm_valid <= asm_valid_nxt;
      asm_addr  <= asm_addr_nxt;
      asm_data  <= asm_data_nxt;
      asm_mask  <= asm_mask_nxt;
      case (state)
        ST_IDLE: if (active && !active_q) begin
          state <= ST_LOAD;
          busy  <= 1'b1;
        end
        ST_LOAD: if (dl_q && !ioctl_download) state <= ST_FLUSH;
        ST_FLUSH: if (!asm_valid && fifo_empty) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  loader_fifo #(.DEPTH(DEPTH), .WIDTH(FIFO_W)) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_w),
    .pop       (DDRAM_WE && !DDRAM_BUSY),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign head_w = ddr_word_t'(head);

  // Wait decodes only registered state so it never depends on ioctl_wr.
  assign ioctl_wait     = (fifo_count >= CW'(DEPTH - 1)) || (state == ST_FLUSH);
  assign DDRAM_WE       = !fifo_empty;
  assign DDRAM_RD       = 1'b0;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = DDRAM_WE ? BASE_ADDR + head_w.addr : '0;
  assign DDRAM_DIN      = DDRAM_WE ? head_w.data : '0;
  assign DDRAM_BE       = DDRAM_WE ? head_w.be : '0;

endmodule

// File: tb/tb_ioctl_ddram_loader.sv
// Randomised self-checking bench for ioctl_ddram_loader against a word-merge model.
module tb_ioctl_ddram_loader;
  import ioctl_ddram_loader_pkg::*;

  localparam logic [7:0]  INDEX = 8'd1;
  localparam logic [28:0] BASE  = 29'h0600000;
  localparam int          DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        DDRAM_BUSY = 1'b0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic        DDRAM_RD;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;

  int        errors = 0;
  int        checks = 0;
  int        done_cnt = 0;
  bit        we_seen = 1'b0;
  bit        prev_hold = 1'b0;
  logic [101:0] prev_out;
  ddr_word_t exp_q[$];
  ddr_word_t got_q[$];
  wr_t       wr_log[$];

  always #5 clk_sys = ~clk_sys;

  ioctl_ddram_loader #(.INDEX(INDEX), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ioctl_download   (ioctl_download),
    .ioctl_index      (ioctl_index),
    .ioctl_wr         (ioctl_wr),
    .ioctl_addr       (ioctl_addr),
    .ioctl_dout       (ioctl_dout),
    .ioctl_wait       (ioctl_wait),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_RD         (DDRAM_RD),
    .busy             (busy),
    .done             (done)
  );

  // Observe the DDRAM port mid-cycle: accepted writes, done pulses, hold stability.
  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (DDRAM_WE) we_seen = 1'b1;
    if (prev_hold && reset_n) begin
      checks++;
      if ({DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE} !== prev_out) begin
        errors++;
        $display("FAIL hold_stable: got %h want %h", {DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE}, prev_out);
      end
    end
    if (DDRAM_WE && !DDRAM_BUSY)
      got_q.push_back('{addr: DDRAM_ADDR, data: DDRAM_DIN, be: DDRAM_BE});
    prev_hold = DDRAM_WE && DDRAM_BUSY && reset_n;
    prev_out  = {DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference: a download is a list of byte writes; each DDRAM word carries
  // the bytes written since the last word change, emitted when all 8 bytes
  // are present, when a different word is touched, or at the end.
  task automatic model_download();
    int          cur = -1;
    logic [63:0] d = '0;
    logic [7:0]  m = '0;
    foreach (wr_log[i]) begin
      int w = int'(wr_log[i].addr) / 8;
      int b = int'(wr_log[i].addr) % 8;
      if (cur >= 0 && w != cur) begin
        exp_q.push_back('{addr: BASE + 29'(cur), data: d, be: m});
        cur = -1;
      end
      if (cur < 0) begin
        cur = w; d = '0; m = '0;
      end
      d[b*8 +: 8]     = wr_log[i].data[7:0];
      d[b*8+8 +: 8]   = wr_log[i].data[15:8];
      m[b]            = 1'b1;
      m[b+1]          = 1'b1;
      if (m == 8'hFF) begin
        exp_q.push_back('{addr: BASE + 29'(cur), data: d, be: m});
        cur = -1;
      end
    end
    if (cur >= 0) exp_q.push_back('{addr: BASE + 29'(cur), data: d, be: m});
    wr_log.delete();
  endtask

  task automatic compare_writes(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes want %0d", name, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_word%0d: got a=%h d=%h be=%h want a=%h d=%h be=%h", name, i,
                   got_q[i].addr, got_q[i].data, got_q[i].be,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].be);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic write(input logic [24:0] addr, input logic [15:0] data);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    if (ioctl_download && ioctl_index == INDEX) wr_log.push_back('{addr: addr, data: data});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    got_q.delete();
    exp_q.delete();
    wr_log.delete();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic finish_dl(input string name, input bit rand_busy);
    int d0 = done_cnt;
    ioctl_download = 1'b0;
    if (!rand_busy) DDRAM_BUSY = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      if (rand_busy) DDRAM_BUSY = ($urandom_range(0, 2) == 0);
      tick();
    end
    DDRAM_BUSY = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: got %b want 0", name, busy);
    end
    model_download();
    compare_writes(name);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({ioctl_wait, DDRAM_WE, DDRAM_RD, DDRAM_BE, busy, done} !== 13'b0) begin
      errors++;
      $display("FAIL %s: got wait=%b we=%b rd=%b be=%h busy=%b done=%b want all 0", name,
               ioctl_wait, DDRAM_WE, DDRAM_RD, DDRAM_BE, busy, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    checks++;
    if (DDRAM_BURSTCNT !== 8'd1) begin
      errors++;
      $display("FAIL burstcnt: got %0d want 1", DDRAM_BURSTCNT);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_sequential();
    start_dl(INDEX);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL seq_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 8; i++) write(25'(i * 2), {8'(i + 1), 8'(i)});
    finish_dl("sequential", 1'b0);
  endtask

  task automatic test_partial();
    start_dl(INDEX);
    write(25'd0, 16'h1111);
    write(25'd2, 16'h2222);
    write(25'd4, 16'h3333);
    finish_dl("partial", 1'b0);
  endtask

  task automatic test_skip();
    start_dl(INDEX);
    write(25'd0, 16'hBEEF);
    write(25'd16, 16'hCAFE);
    finish_dl("skip", 1'b0);
  endtask

  task automatic test_zero_writes();
    start_dl(INDEX);
    tick();
    finish_dl("zero_writes", 1'b0);
  endtask

  task automatic test_backpressure();
    start_dl(INDEX);
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      write(25'(i * 2), 16'($urandom));
      if (i == 7) begin
        checks++;
        if (ioctl_wait !== 1'b0) begin
          errors++;
          $display("FAIL bp_wait_at2: got %b want 0", ioctl_wait);
        end
      end
      if (i == 11 || i == 15) begin
        checks++;
        if (ioctl_wait !== 1'b1) begin
          errors++;
          $display("FAIL bp_wait_at%0d: got %b want 1", (i + 1) / 4, ioctl_wait);
        end
      end
    end
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_no_write_while_busy: got %0d writes want 0", got_q.size());
    end
    finish_dl("backpressure", 1'b0);
  endtask

  task automatic test_wrong_index();
    bit bad = 1'b0;
    we_seen = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) begin
      write(25'(i * 2), 16'($urandom));
      if (busy !== 1'b0 || ioctl_wait !== 1'b0) bad = 1'b1;
    end
    ioctl_download = 1'b0;
    repeat (5) tick();
    checks++;
    if (bad || we_seen) begin
      errors++;
      $display("FAIL wrong_index: got we_seen=%b busy_or_wait=%b want 0/0", we_seen, bad);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(20, 60);
      start_dl(INDEX);
      for (int k = 0; k < n; k++) begin
        DDRAM_BUSY = $urandom_range(0, 1);
        if (ioctl_wait || $urandom_range(0, 3) == 0) tick();
        else write(25'($urandom_range(0, 5) * 8 + $urandom_range(0, 3) * 2), 16'($urandom));
      end
      finish_dl($sformatf("random%0d", r), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    start_dl(INDEX);
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) write(25'(i * 2), 16'($urandom));
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check_reset_outputs("reset_mid_outputs");
    repeat (2) tick();
    reset_n    = 1'b1;
    DDRAM_BUSY = 1'b0;
    we_seen    = 1'b0;
    repeat (20) tick();
    checks++;
    if (we_seen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got we_seen=%b busy=%b want 0/0", we_seen, busy);
    end
    wr_log.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_partial();
    test_skip();
    test_zero_writes();
    test_backpressure();
    test_wrong_index();
    test_random();
    test_reset_mid();
    test_sequential();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
